// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK demodulator slice.
//   SAMPLES_PER_SYMBOL : samples per symbol period
//   SYMBOLS_PER_FRAME  : symbols per frame (21 data bits + 1 pad bit)
//   FRAME_BITS         : decoded data bits per frame
//   MIDSCALE           : offset-binary zero level of the sample stream
//   ACC_W              : correlator accumulator width (signed)
//   demod_state_e      : demodulator control states
package qpsk_pkg;

  localparam int unsigned SAMPLES_PER_SYMBOL = 40;
  localparam int unsigned SYMBOLS_PER_FRAME  = 11;
  localparam int unsigned FRAME_BITS         = 21;
  localparam int unsigned MIDSCALE           = 32768;
  localparam int unsigned ACC_W              = 22;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } demod_state_e;

endpackage

// File: rtl/qpsk_refsign.sv
// Reference-carrier sign lookup for the correlator.
//   idx_i   : in-symbol sample index n
//   i_neg_o : 1 when the in-phase reference is -1 (cos quadrant sign)
//   q_neg_o : 1 when the quadrature reference is -1 (sin half-period sign)
module qpsk_refsign
  import qpsk_pkg::*;
#(
  parameter int unsigned SPS = SAMPLES_PER_SYMBOL
) (
  input  logic [5:0] idx_i,
  output logic       i_neg_o,
  output logic       q_neg_o
);

  localparam logic [5:0] I_LO = 6'(SPS / 4);
  localparam logic [5:0] I_HI = 6'((3 * SPS) / 4);
  localparam logic [5:0] Q_LO = 6'(SPS / 2);

  always_comb begin
    i_neg_o = (idx_i >= I_LO) && (idx_i < I_HI);
    q_neg_o = (idx_i >= Q_LO);
  end

endmodule

// File: rtl/qpsk_demod.sv
// QPSK frame demodulator: correlates each symbol against square-wave I/Q
// references, slices the quadrant into two bits and assembles a frame word.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   indata     : offset-binary sample (MIDSCALE is zero)
//   readready  : indata valid this cycle
//   waitread   : 1 while accepting samples
//   outdata    : decoded 21-bit frame word
//   writeready : outdata valid, held until accepted
//   waitwrite  : downstream accepts outdata
//   padflag    : decoded pad bit, valid with writeready
//   complete   : one-cycle pulse after a frame transfer
module qpsk_demod #(
  parameter int unsigned SAMPLES_PER_SYMBOL = qpsk_pkg::SAMPLES_PER_SYMBOL,
  parameter int unsigned SYMBOLS_PER_FRAME  = qpsk_pkg::SYMBOLS_PER_FRAME
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     indata,
  input  logic                            readready,
  output logic                            waitread,
  output logic [qpsk_pkg::FRAME_BITS-1:0] outdata,
  output logic                            writeready,
  input  logic                            waitwrite,
  output logic                            padflag,
  output logic                            complete
);

  localparam int unsigned ACC_W = qpsk_pkg::ACC_W;
  localparam int unsigned FB    = qpsk_pkg::FRAME_BITS;
  localparam int unsigned BUF_W = FB + 1;
  localparam int unsigned CNT_W = $clog2(SYMBOLS_PER_FRAME + 1);

  localparam logic [5:0]       LAST_N   = 6'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMBOLS_PER_FRAME - 1);

  qpsk_pkg::demod_state_e state_q;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] acc_i_d, acc_q_d;
  logic [5:0]              n_q;
  logic [CNT_W-1:0]        sym_q;
  logic [BUF_W-1:0]        frame_q, frame_d;
  logic                    waitread_q, writeready_q, padflag_q, complete_q;
  logic [FB-1:0]           outdata_q;

  logic signed [16:0]      s;
  logic signed [ACC_W-1:0] s_ext;
  logic                    i_neg, q_neg;
  logic                    b1, b0;
  logic                    last_n;

  qpsk_refsign #(
    .SPS(SAMPLES_PER_SYMBOL)
  ) u_refsign (
    .idx_i  (n_q),
    .i_neg_o(i_neg),
    .q_neg_o(q_neg)
  );

  // The decision looks at the accumulator values that already include the
  // current sample, so the last sample of a symbol is folded in and sliced
  // in the same cycle and the stream never stalls between symbols.
  always_comb begin
    s       = signed'({1'b0, indata}) - signed'(17'(qpsk_pkg::MIDSCALE));
    s_ext   = ACC_W'(s);
    acc_i_d = i_neg ? (acc_i_q - s_ext) : (acc_i_q + s_ext);
    acc_q_d = q_neg ? (acc_q_q - s_ext) : (acc_q_q + s_ext);
    b1      = acc_i_d[ACC_W-1];
    b0      = acc_i_d[ACC_W-1] ^ acc_q_d[ACC_W-1];
    frame_d = {frame_q[BUF_W-3:0], b1, b0};
    last_n  = (n_q == LAST_N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= qpsk_pkg::IDLE;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      n_q          <= '0;
      sym_q        <= '0;
      frame_q      <= '0;
      waitread_q   <= 1'b0;
      writeready_q <= 1'b0;
      padflag_q    <= 1'b0;
      complete_q   <= 1'b0;
      outdata_q    <= '0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        qpsk_pkg::IDLE: begin
          state_q    <= qpsk_pkg::ACCUM;
          waitread_q <= 1'b1;
        end

        qpsk_pkg::ACCUM: begin
          if (readready) begin
            if (last_n) begin
              acc_i_q <= '0;
              acc_q_q <= '0;
              n_q     <= '0;
              frame_q <= frame_d;
              sym_q   <= sym_q + 1'b1;
              if (sym_q == LAST_SYM) begin
                state_q      <= qpsk_pkg::HOLD;
                waitread_q   <= 1'b0;
                writeready_q <= 1'b1;
                outdata_q    <= frame_d[BUF_W-1:1];
                padflag_q    <= frame_d[0];
              end
            end else begin
              acc_i_q <= acc_i_d;
              acc_q_q <= acc_q_d;
              n_q     <= n_q + 1'b1;
            end
          end
        end

        qpsk_pkg::HOLD: begin
          if (waitwrite) begin
            state_q      <= qpsk_pkg::ACCUM;
            waitread_q   <= 1'b1;
            writeready_q <= 1'b0;
            complete_q   <= 1'b1;
            sym_q        <= '0;
            frame_q      <= '0;
          end
        end

        default: begin
          state_q    <= qpsk_pkg::IDLE;
          waitread_q <= 1'b0;
        end
      endcase
    end
  end

  assign waitread   = waitread_q;
  assign writeready = writeready_q;
  assign padflag    = padflag_q;
  assign complete   = complete_q;
  assign outdata    = outdata_q;

endmodule

// File: tb/tb_qpsk_demod.sv
module tb_qpsk_demod;

  logic        clk;
  logic        reset;
  logic [15:0] indata;
  logic        readready;
  logic        waitread;
  logic [20:0] outdata;
  logic        writeready;
  logic        waitwrite;
  logic        padflag;
  logic        complete;

  int tests = 0;
  int fails = 0;
  int popped = 0;
  int pushed = 0;

  logic [21:0] exp_q[$];

  qpsk_demod #(
    .SAMPLES_PER_SYMBOL(40),
    .SYMBOLS_PER_FRAME (11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .indata    (indata),
    .readready (readready),
    .waitread  (waitread),
    .outdata   (outdata),
    .writeready(writeready),
    .waitwrite (waitwrite),
    .padflag   (padflag),
    .complete  (complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Modulator sample: carrier cos(2*pi*n/40 - phase), amplitude 16000 about midscale.
  function automatic logic [15:0] samp(input int n, input int phdeg);
    real pi, r;
    pi = 3.14159265358979;
    r  = 16000.0 * $cos(2.0 * pi * n / 40.0 - phdeg * pi / 180.0);
    return 16'(32768 + $rtoi(r));
  endfunction

  function automatic int phase_of(input logic [1:0] bits);
    case (bits)
      2'b00:   return 45;
      2'b01:   return 315;
      2'b10:   return 225;
      default: return 135;
    endcase
  endfunction

  // Monitor: pops expected frames when writeready rises, checks hold
  // stability and the complete pulse following each transfer.
  logic        prev_wr   = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [21:0] held      = '0;
  logic [21:0] exp_w;

  always @(negedge clk) begin
    if (reset) begin
      prev_wr   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (complete || prev_xfer) begin
        chk("complete_pulse", {31'd0, complete}, {31'd0, prev_xfer});
        if (complete) chk("waitread_after_complete", {31'd0, waitread}, 32'd1);
      end
      if (writeready && !prev_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {10'd0, outdata, padflag}, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          popped++;
          chk("outdata", {11'd0, outdata}, {11'd0, exp_w[21:1]});
          chk("padflag", {31'd0, padflag}, {31'd0, exp_w[0]});
        end
      end else if (writeready && prev_wr) begin
        chk("hold_stable", {10'd0, outdata, padflag}, {10'd0, held});
        chk("hold_waitread", {31'd0, waitread}, 32'd0);
      end
      held      = {outdata, padflag};
      prev_wr   = writeready;
      prev_xfer = writeready && waitwrite;
    end
  end

  // nsamp < 440 sends a partial frame that must never produce output.
  task automatic send_frame(input logic [20:0] data, input logic pad, input bit gappy,
                            input int hold, input int nsamp);
    logic [21:0] word;
    int cnt, budget, sym, n;
    bit rr, acc;
    word = {data, pad};
    if (nsamp == 440) begin
      exp_q.push_back(word);
      pushed++;
    end
    waitwrite = (hold == 0);
    budget = 50;
    while (!waitread && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) chk("wait_for_waitread", {31'd0, waitread}, 32'd1);
    cnt = 0;
    budget = 4 * nsamp + 50;
    while (cnt < nsamp && budget > 0) begin
      sym = cnt / 40;
      n   = cnt % 40;
      rr  = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      readready = rr;
      indata = rr ? samp(n, phase_of(word[21-2*sym -: 2])) : 16'($urandom);
      acc = rr && waitread;
      @(posedge clk); #1;
      if (acc) cnt++;
      budget--;
    end
    readready = 1'b0;
    if (cnt < nsamp) chk("sample_budget", cnt, nsamp);
    if (nsamp == 440) begin
      chk("latency_writeready", {31'd0, writeready}, 32'd1);
      chk("frame_end_waitread", {31'd0, waitread}, 32'd0);
      if (hold > 0) begin
        readready = 1'b1;
        repeat (hold) begin
          indata = 16'($urandom);
          @(posedge clk); #1;
          chk("held_writeready", {31'd0, writeready}, 32'd1);
          chk("held_waitread", {31'd0, waitread}, 32'd0);
        end
        waitwrite = 1'b1;
        @(posedge clk); #1;
        readready = 1'b0;
        chk("xfer_writeready_low", {31'd0, writeready}, 32'd0);
        chk("xfer_complete", {31'd0, complete}, 32'd1);
        @(posedge clk); #1;
        chk("complete_one_cycle", {31'd0, complete}, 32'd0);
        chk("resume_waitread", {31'd0, waitread}, 32'd1);
      end else begin
        @(posedge clk); #1;
        chk("xfer_writeready_low", {31'd0, writeready}, 32'd0);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    indata    = '0;
    readready = 1'b0;
    waitwrite = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitread", {31'd0, waitread}, 32'd0);
    chk("rst_writeready", {31'd0, writeready}, 32'd0);
    chk("rst_complete", {31'd0, complete}, 32'd0);
    chk("rst_padflag", {31'd0, padflag}, 32'd0);
    chk("rst_outdata", {11'd0, outdata}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_to_accum", {31'd0, waitread}, 32'd1);

    send_frame(21'h000000, 1'b0, 1'b0, 0, 440);
    send_frame(21'h1FFFFF, 1'b0, 1'b0, 0, 440);
    send_frame(21'h155555, 1'b0, 1'b1, 0, 440);
    send_frame(21'h0F0F0F, 1'b1, 1'b0, 5, 440);

    send_frame(21'h000000, 1'b0, 1'b0, 0, 17);
    do_reset(2);
    chk("midframe_rst_waitread", {31'd0, waitread}, 32'd0);
    send_frame(21'h0A5A5A, 1'b0, 1'b0, 0, 440);

    send_frame(21'h000001, 1'b1, 1'b0, 0, 440);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("frames_seen", popped, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
